// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the controller state encoding and the default operand width.
package mult_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_add_row.sv
// One 2W-bit ripple row of full adders; when i_en is low the row passes i_a through unchanged.
module mult_add_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_en,
    output logic [N-1:0] o_sum
);

    logic [N:0]   w_carry;
    logic [N-1:0] w_b_gated;

    assign w_carry[0] = 1'b0;
    assign w_b_gated  = i_en ? i_b : '0;

    // Carry out of the top bit is dropped; the caller guarantees it cannot be set.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_sum[i]     = i_a[i] ^ w_b_gated[i] ^ w_carry[i];
        assign w_carry[i+1] = (i_a[i] & w_b_gated[i]) | (w_carry[i] & (i_a[i] ^ w_b_gated[i]));
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential W x W multiplier: one multiplier bit per cycle, LSB first, with sign-magnitude
// handling for two's-complement requests and a valid/ready handshake on both sides.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int CW = $clog2(W + 1);

    state_t         r_state;
    state_t         w_next_state;
    logic [CW-1:0]  r_count;
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic           r_neg;
    logic [2*W-1:0] r_product;

    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [2*W-1:0] w_sum;
    logic           w_accept;
    logic           w_last;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_state == BUSY) && (r_count == CW'(W - 1));

    // Magnitudes are W-bit unsigned, so the most negative operand maps to 2^(W-1).
    assign w_mag_a = (signed_mode && a[W-1]) ? -a : a;
    assign w_mag_b = (signed_mode && b[W-1]) ? -b : b;

    mult_add_row #(
        .N (2 * W)
    ) u_add_row (
        .i_a   (r_acc),
        .i_b   (r_mcand),
        .i_en  (r_mplier[0]),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (r_count == CW'(W - 1)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The product register only changes on the final BUSY edge, so it holds through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= {{W{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= signed_mode && (a[W-1] ^ b[W-1]);
        end else if (r_state == BUSY) begin
            r_count  <= r_count + CW'(1);
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_product <= r_neg ? -w_sum : w_sum;
            end
        end
    end

    assign product = r_product;

endmodule
